// File: rtl/pipelined_multiplier_arbiter_pkg.sv
// Shared types for the multiplier arbiter: tag format and id sizing helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipelined_multiplier_pkg;

    // $clog2 that never returns 0, so a 1-client build still has a 1-bit id.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // The tag id is sized for the largest supported client count so a single
    // tag type serves every instance; narrower instances zero the upper bits.
    localparam int MAX_REQUESTERS = 16;
    localparam int ID_WIDTH       = clog2_min1(MAX_REQUESTERS);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/pipelined_multiplier_arbiter_if.sv
// Bundle of client request/response lanes plus the shared-multiplier port.
// Latency: n/a (wires only).
// Backpressure: resp_ready_i per client; slave = arbiter, master = environment.
interface pipelined_multiplier_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REQUESTERS = 4
);
    // client request side
    logic [REQUESTERS-1:0]                 req_valid_i;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_operand_A_i;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] req_operand_B_i;
    logic [REQUESTERS-1:0]                 req_ready_o;
    // client response side
    logic [REQUESTERS-1:0]                 resp_valid_o;
    logic [REQUESTERS-1:0]                 resp_ready_i;
    logic [2*DATA_WIDTH-1:0]               resp_result_o;
    // multiplier side
    logic                                  mul_clk_en_o;
    logic [DATA_WIDTH-1:0]                 mul_operand_A_o;
    logic [DATA_WIDTH-1:0]                 mul_operand_B_o;
    logic                                  mul_valid_entry_o;
    logic [2*DATA_WIDTH-1:0]               mul_result_i;
    // status
    logic                                  busy_o;

    modport slave (
        input  req_valid_i, req_operand_A_i, req_operand_B_i, resp_ready_i, mul_result_i,
        output req_ready_o, resp_valid_o, resp_result_o, mul_clk_en_o,
               mul_operand_A_o, mul_operand_B_o, mul_valid_entry_o, busy_o
    );

    modport master (
        output req_valid_i, req_operand_A_i, req_operand_B_i, resp_ready_i, mul_result_i,
        input  req_ready_o, resp_valid_o, resp_result_o, mul_clk_en_o,
               mul_operand_A_o, mul_operand_B_o, mul_valid_entry_o, busy_o
    );
endinterface

// File: rtl/pipelined_multiplier_arbiter_rr.sv
// Round-robin grant among req bits, searching upward from a rotating pointer.
// Latency: grant is combinational; pointer moves on the edge where advance=1.
// Backpressure: pointer holds while advance=0, so pending requests keep order.
// Ports: clk/rst, req vector, advance; outputs one-hot grant and grant_idx.
module round_robin_arbiter
    import pipelined_multiplier_pkg::*;
#(
    parameter int REQUESTERS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQUESTERS-1:0] req,
    input  logic                  advance,
    output logic [REQUESTERS-1:0] grant,
    output logic [ID_WIDTH-1:0]   grant_idx
);
    logic [ID_WIDTH-1:0]   ptr;
    logic [REQUESTERS-1:0] rot;
    logic                  found;
    int                    pos;

    // Rotate so bit j of rot is client (ptr+j) mod REQUESTERS; the first set
    // bit of rot is then the round-robin winner.
    always_comb begin
        rot       = REQUESTERS'({req, req} >> ptr);
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int j = 0; j < REQUESTERS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = int'(ptr) + j;
            end
        end
        if (pos >= REQUESTERS) begin
            pos = pos - REQUESTERS;
        end
        if (found) begin
            grant_idx = ID_WIDTH'(pos);
            grant     = REQUESTERS'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == ID_WIDTH'(REQUESTERS - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
        end
    end
endmodule

// File: rtl/pipelined_multiplier_arbiter.sv
// Shares one pipelined multiplier among REQUESTERS clients, routing results back by tag.
// Latency: result on resp_valid_o PIPELINE_DEPTH-1 cycles after acceptance, plus stall cycles.
// Backpressure: head result not accepted -> multiplier clock enable, tags and issue all freeze.
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport: client lanes + multiplier port).
module pipelined_multiplier_arbiter
    import pipelined_multiplier_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int PIPELINE_DEPTH = 4,
    parameter int REQUESTERS     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    pipelined_multiplier_arbiter_if.slave bus
);
    localparam int LAT = PIPELINE_DEPTH - 1;

    // tags[0] lines up with the multiplier output; tags[LAT-1] is the tail.
    mul_tag_t tags [LAT];
    mul_tag_t tail_tag;

    logic [REQUESTERS-1:0] grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  head_vld;
    logic                  stall;
    logic                  accept;
    logic                  busy;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    // Our valid bit is authoritative; the multiplier's own contents may be stale.
    assign head_vld = tags[0].valid & ~rst_i;
    assign stall    = head_vld & ~|(bus.resp_ready_i & (REQUESTERS'(1) << tags[0].id));
    assign accept   = ~stall & ~rst_i & (|bus.req_valid_i);

    round_robin_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_rr (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (bus.req_valid_i),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot AND-OR operand mux; zero operands when nothing issues.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (accept && grant[i]) begin
                op_a = bus.req_operand_A_i[i];
                op_b = bus.req_operand_B_i[i];
            end
        end
    end

    always_comb begin
        tail_tag.valid = accept;
        tail_tag.id    = accept ? grant_idx : '0;
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tags[i].valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LAT; i++) begin
                tags[i] <= '0;
            end
        end else if (!stall) begin
            for (int i = 0; i < LAT - 1; i++) begin
                tags[i] <= tags[i+1];
            end
            tags[LAT-1] <= tail_tag;
        end
    end

    assign bus.mul_clk_en_o      = ~stall;
    assign bus.mul_valid_entry_o = accept;
    assign bus.mul_operand_A_o   = op_a;
    assign bus.mul_operand_B_o   = op_b;
    assign bus.req_ready_o       = accept ? grant : '0;
    assign bus.resp_valid_o      = head_vld ? (REQUESTERS'(1) << tags[0].id) : '0;
    assign bus.resp_result_o     = bus.mul_result_i;
    assign bus.busy_o            = busy;
endmodule

// File: tb/tb_pipelined_multiplier_arbiter.sv
// Bench for pipelined_multiplier_arbiter: directed cases then random traffic
// against a queue-based model of in-flight operations.
module tb_pipelined_multiplier_arbiter;
    localparam int DW  = 16;
    localparam int PD  = 4;
    localparam int NR  = 4;
    localparam int LAT = PD - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipelined_multiplier_arbiter_if #(.DATA_WIDTH(DW), .REQUESTERS(NR)) bus ();

    pipelined_multiplier_arbiter #(
        .DATA_WIDTH     (DW),
        .PIPELINE_DEPTH (PD),
        .REQUESTERS     (NR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Stand-in for the shared multiplier: LAT enabled cycles, no reset.
    logic [2*DW-1:0] mstage [LAT];
    always @(posedge clk) begin
        if (bus.mul_clk_en_o) begin
            for (int i = 0; i < LAT - 1; i++) mstage[i] <= mstage[i+1];
            mstage[LAT-1] <= {16'b0, bus.mul_operand_A_o} * {16'b0, bus.mul_operand_B_o};
        end
    end
    assign bus.mul_result_i = mstage[0];

    // Client state
    logic [NR-1:0] pend, hold, rrdy;
    logic [DW-1:0] opa [NR];
    logic [DW-1:0] opb [NR];

    // Reference model: in-order list of operations with remaining enabled cycles.
    typedef struct {
        int          id;
        logic [31:0] prod;
        int          rem;
    } op_t;
    op_t q[$];
    int  mptr;

    int checks = 0;
    int errors = 0;

    logic [NR-1:0] o_rv, o_rdy;
    logic [31:0]   o_res;
    logic          o_en, o_busy, o_ve;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid_i  = pend;
        bus.resp_ready_i = rrdy;
        for (int i = 0; i < NR; i++) begin
            bus.req_operand_A_i[i] = opa[i];
            bus.req_operand_B_i[i] = opb[i];
        end
    endtask

    // One clock cycle: drive, sample at negedge, check against the model,
    // advance the model as the coming edge will, then move past the edge.
    task automatic cycle();
        int            g;
        logic          front, exp_stall;
        logic [NR-1:0] exp_rv, exp_rdy;
        logic [31:0]   p;
        drive();
        @(negedge clk);
        o_rv   = bus.resp_valid_o;
        o_rdy  = bus.req_ready_o;
        o_res  = bus.resp_result_o;
        o_en   = bus.mul_clk_en_o;
        o_busy = bus.busy_o;
        o_ve   = bus.mul_valid_entry_o;
        if (rst) begin
            chk("rst_req_ready", o_rdy, 0);
            chk("rst_resp_valid", o_rv, 0);
            chk("rst_clk_en", o_en, 1);
            chk("rst_valid_entry", o_ve, 0);
            q.delete();
            mptr = 0;
        end else begin
            front     = (q.size() > 0) && (q[0].rem == 0);
            exp_rv    = front ? (NR'(1) << q[0].id) : '0;
            exp_stall = front && !rrdy[q[0].id];
            g = -1;
            if (!exp_stall) begin
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (mptr + k) % NR;
                    if (g < 0 && pend[c]) g = c;
                end
            end
            exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
            chk("resp_valid", o_rv, exp_rv);
            if (front) chk("resp_result", o_res, q[0].prod);
            chk("mul_clk_en", o_en, !exp_stall);
            chk("req_ready", o_rdy, exp_rdy);
            chk("mul_valid_entry", o_ve, g >= 0);
            chk("busy", o_busy, q.size() > 0);
            chk("mul_operand_A", bus.mul_operand_A_o, (g >= 0) ? opa[g] : '0);
            chk("mul_operand_B", bus.mul_operand_B_o, (g >= 0) ? opb[g] : '0);
            if (!exp_stall) begin
                if (front) void'(q.pop_front());
                for (int k = 0; k < q.size(); k++) if (q[k].rem > 0) q[k].rem--;
                if (g >= 0) begin
                    p = {16'b0, opa[g]} * {16'b0, opb[g]};
                    q.push_back('{id: g, prod: p, rem: LAT - 1});
                    mptr = (g + 1) % NR;
                    if (!hold[g]) pend[g] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        pend = '0;
        hold = '0;
        rrdy = '1;
        for (int i = 0; i < NR; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        cycle();
        chk("reset_busy", o_busy, 0);
        chk("reset_clk_en", o_en, 1);

        // 1. Single request 3x5 from client 0
        pend[0] = 1'b1; opa[0] = 3; opb[0] = 5;
        cycle();
        chk("t1_ready", o_rdy, 4'b0001);
        idle(3);
        chk("t1_resp_valid", o_rv, 4'b0001);
        chk("t1_result", o_res, 15);
        cycle();
        chk("t1_busy_after", o_busy, 0);

        // 2. Fairness: all clients continuously valid, A=i+1, B=10
        do_reset();
        for (int i = 0; i < NR; i++) begin
            opa[i] = DW'(i + 1);
            opb[i] = 10;
        end
        hold = '1;
        pend = '1;
        for (int k = 0; k < NR; k++) begin
            cycle();
            chk("t2_grant", o_rdy, NR'(1) << k);
        end
        chk("t2_first_valid", o_rv, 4'b0001);
        chk("t2_first_result", o_res, 10);

        // 3. Client 1 holds off its result for 4 cycles
        rrdy = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_stall_clk_en", o_en, 0);
            chk("t3_stall_ready", o_rdy, 0);
            chk("t3_stall_valid", o_rv, 4'b0010);
            chk("t3_stall_result", o_res, 20);
        end
        rrdy = 4'b1111;
        cycle();
        chk("t3_release_result", o_res, 20);
        chk("t3_release_clk_en", o_en, 1);
        cycle();
        chk("t3_next_valid", o_rv, 4'b0100);
        chk("t3_next_result", o_res, 30);
        cycle();
        chk("t3_last_valid", o_rv, 4'b1000);
        chk("t3_last_result", o_res, 40);
        cycle();
        chk("t3_wrap_result", o_res, 10);
        hold = '0;
        pend = '0;
        idle(LAT + 2);

        // 4. Maximum operands from client 2
        pend[2] = 1'b1; opa[2] = 16'hFFFF; opb[2] = 16'hFFFF;
        cycle();
        chk("t4_ready", o_rdy, 4'b0100);
        idle(3);
        chk("t4_resp_valid", o_rv, 4'b0100);
        chk("t4_result", o_res, 32'hFFFE_0001);
        idle(2);

        // 5. Reset with three operations in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            opa[i] = DW'(i + 2);
            opb[i] = DW'(i + 5);
        end
        pend = 4'b0111;
        idle(3);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t5_no_resp", o_rv, 0);
        end
        chk("t5_busy", o_busy, 0);
        pend[3] = 1'b1; opa[3] = 7; opb[3] = 9;
        cycle();
        chk("t5_ready", o_rdy, 4'b1000);
        idle(3);
        chk("t5_resp_valid", o_rv, 4'b1000);
        chk("t5_result", o_res, 63);
        idle(2);

        // 6. Pointer wrap from client 3 back to client 0
        do_reset();
        pend[3] = 1'b1; opa[3] = 2; opb[3] = 2;
        cycle();
        chk("t6_first", o_rdy, 4'b1000);
        pend = 4'b1001; opa[0] = 4; opb[0] = 4;
        cycle();
        chk("t6_wrap_to_0", o_rdy, 4'b0001);
        cycle();
        chk("t6_then_3", o_rdy, 4'b1000);
        idle(LAT + 2);

        // Random traffic with random result backpressure and rare resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    opa[i]  = DW'($urandom);
                    opb[i]  = DW'($urandom);
                end
                rrdy[i] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 99) == 0);
            cycle();
            rst = 1'b0;
        end

        // Drain
        pend = '0;
        rrdy = '1;
        for (int n = 0; n < 50 && q.size() > 0; n++) cycle();
        chk("drain_empty", q.size(), 0);
        cycle();
        chk("drain_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
